// File: rtl/seq_divider.sv
// Multicycle signed restoring divider: one quotient bit per clock, MIPS DIV
// semantics (quotient truncates toward zero, remainder takes the dividend's sign).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stop,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, DZERO} state_t;

  state_t           state, nextState;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic             sA, sQ;

  logic [WIDTH-1:0] magA, magB, diff;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic             divByZero;

  // Unsigned negate on purpose: the most negative value maps onto itself,
  // which is exactly the magnitude an unsigned restoring step needs.
  assign magA      = A[WIDTH-1] ? -A : A;
  assign magB      = B[WIDTH-1] ? -B : B;
  assign divByZero = (B == '0);

  assign shifted = {rem, quot[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor});
  assign diff    = shifted[WIDTH-1:0] - divisor;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = divByZero ? DZERO : CALC;
      CALC:    if (count == LAST_STEP) nextState = FIX;
      FIX:     nextState = DONE;
      DONE:    nextState = IDLE;
      DZERO:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count   <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      sA      <= 1'b0;
      sQ      <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !divByZero) begin
            quot    <= magA;
            divisor <= magB;
            rem     <= '0;
            sA      <= A[WIDTH-1];
            sQ      <= A[WIDTH-1] ^ B[WIDTH-1];
            count   <= '0;
          end
        end
        CALC: begin
          // quot doubles as the dividend shift register; quotient bits fill from the right.
          rem   <= fits ? diff : shifted[WIDTH-1:0];
          quot  <= {quot[WIDTH-2:0], fits};
          count <= count + 1'b1;
        end
        FIX: begin
          LO <= sQ ? -quot : quot;
          HI <= sA ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state == CALC) || (state == FIX);
  assign Stop    = (state == DONE) || (state == DZERO);
  assign DivZero = (state == DZERO);

endmodule
